nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer_pkg.sv | 31 +++
 rtl/packer_fifo.sv | 66 ++++++
 rtl/nibble_packer.sv | 100 ++++++++++
 tb/tb_nibble_packer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_pkg.sv
// nibble_packer_pkg
// Shared widths, the FIFO entry type and the lane-insert helper used by the
// nibble packer and its output FIFO.
//   LANES  : nibble lanes per packed word
//   NIB_W  : width of one nibble lane
//   WORD_W : width of a packed word (LANES * NIB_W)
//   SEL_W  : width of the lane index
//   entry_t: one FIFO entry, {partial, word}
package nibble_packer_pkg;

  localparam int LANES  = 4;
  localparam int NIB_W  = 4;
  localparam int WORD_W = 16;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic              partial;
    logic [WORD_W-1:0] word;
  } entry_t;

  // Returns w with lane 'lane' replaced by nib; lane n lives at [4n+3:4n].
  function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] w,
                                                 input logic [SEL_W-1:0]  lane,
                                                 input logic [NIB_W-1:0]  nib);
    logic [WORD_W-1:0] r;
    r = w;
    r[lane*NIB_W +: NIB_W] = nib;
    return r;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// packer_fifo
// Synchronous FIFO of packed-word entries with registered occupancy.
//   clk, reset : clock, asynchronous active-high reset of pointers/level
//   push       : request to write push_entry (accepted if not full, or if a
//                pop takes effect at the same edge)
//   push_entry : entry to write
//   pop        : request to drop the head entry (ignored when empty)
//   head       : current head entry, all zeros while empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module packer_fifo
  import nibble_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop at the same edge frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; the empty mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer
// Collects 4-bit nibbles into 16-bit words by lane index and queues each
// closed word (plus a partial flag) in an output FIFO.
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : qualifies sel/data this cycle
//   sel         : lane index of the nibble; lane 3 closes the word
//   data        : nibble for lane sel
//   out_ready   : downstream accepts the head word this cycle
//   out_valid   : FIFO head is valid (level != 0)
//   out_word    : head word, lane n at [4n+3:4n]
//   out_partial : head word was closed with an unwritten lane
//   level       : FIFO occupancy
//   overflow    : sticky, a closed word was dropped at full FIFO
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NIB_W-1:0]         data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_word,
  output logic                     out_partial,
  output logic [$clog2(DEPTH):0]   level
  ,
  output logic                     overflow
);

  logic [WORD_W-1:0] asm_word_p0;
  logic [LANES-1:0]  asm_mask_p0;
  logic [WORD_W-1:0] word_next;
  logic [LANES-1:0]  mask_next;
  logic              close;
  logic              pop;
  logic              full;
  logic              empty;
  entry_t            push_entry;
  entry_t            head;

  // Assembly state as it would be after this cycle's nibble; the closing
  // word is pushed from here so the last lane lands in the same edge.
  always_comb begin
    word_next = asm_word_p0;
    mask_next = asm_mask_p0;
    if (in_valid) begin
      word_next      = set_lane(asm_word_p0, sel, data);
      mask_next[sel] = 1'b1;
    end
  end

  assign close              = in_valid && (sel == SEL_W'(LANES - 1));
  assign push_entry.partial = ~&mask_next;
  assign push_entry.word    = word_next;

  // ---- stage p0: assembly register and lane mask ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_word_p0 <= '0;
      asm_mask_p0 <= '0;
    end else if (close) begin
      asm_word_p0 <= '0;
      asm_mask_p0 <= '0;
    end else if (in_valid) begin
      asm_word_p0 <= word_next;
      asm_mask_p0 <= mask_next;
    end
  end

  // A closed word is lost only when the FIFO is full and nothing leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (close && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // ---- stage p1: output FIFO ----
  packer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (close),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign out_word    = head.word;
  assign out_partial = head.partial;

endmodule

// File: tb/tb_nibble_packer.sv
module tb_nibble_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  sel;
  logic [3:0]  data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_word;
  logic        out_partial;
  logic [2:0]  level;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of {partial, word}, per-lane nibbles and flags.
  logic [16:0] mq[$];
  logic [3:0]  m_nib[4];
  bit          m_set[4];
  bit          m_ovf;

  nibble_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .sel         (sel),
    .data        (data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_word    (out_word),
    .out_partial (out_partial),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_clear_asm();
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 4'h0;
      m_set[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    model_clear_asm();
  endtask

  // Applies the rules of one clock edge to the model.
  task automatic model_edge(input bit v, input logic [1:0] s, input logic [3:0] d, input bit r);
    bit          popped;
    logic [16:0] e;
    popped = (mq.size() != 0) && r;
    if (popped) void'(mq.pop_front());
    if (v) begin
      m_nib[s] = d;
      m_set[s] = 1'b1;
      if (s == 2'd3) begin
        e[15:0] = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        e[16]   = !(m_set[0] && m_set[1] && m_set[2] && m_set[3]);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
        model_clear_asm();
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic drive(input bit v, input logic [1:0] s, input logic [3:0] d, input bit r);
    in_valid  = v;
    sel       = s;
    data      = d;
    out_ready = r;
    @(posedge clk);
    model_edge(v, s, d, r);
    #1;
  endtask

  task automatic reset_assert();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic reset_release();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      sel       = 2'(i + 1);
      data      = 4'hF;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_word !== 16'h0) begin n_err++; $display("FAIL reset.out_word: got %h expected 0000", out_word); end
    n_vec++; if (out_partial !== 1'b0) begin n_err++; $display("FAIL reset.out_partial: got %b expected 0", out_partial); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset.level: got %0d expected 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset.overflow: got %b expected 0", overflow); end
    in_valid = 1'b0;
    reset_release();
  endtask

  task automatic test_full_word();
    drive(1, 2'd0, 4'h1, 1);
    drive(1, 2'd1, 4'h2, 1);
    drive(1, 2'd2, 4'h3, 1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_word.early_valid: got %b expected 0", out_valid); end
    drive(1, 2'd3, 4'h4, 1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_word.valid: got %b expected 1", out_valid); end
    n_vec++; if (out_word !== 16'h4321) begin n_err++; $display("FAIL full_word.word: got %h expected 4321", out_word); end
    n_vec++; if (out_partial !== 1'b0) begin n_err++; $display("FAIL full_word.partial: got %b expected 0", out_partial); end
    drive(0, 2'd0, 4'h0, 1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_word.one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_partial();
    drive(1, 2'd0, 4'hA, 1);
    drive(1, 2'd3, 4'hB, 1);
    n_vec++; if (out_word !== 16'hB00A) begin n_err++; $display("FAIL partial.word: got %h expected B00A", out_word); end
    n_vec++; if (out_partial !== 1'b1) begin n_err++; $display("FAIL partial.flag: got %b expected 1", out_partial); end
    drive(0, 2'd0, 4'h0, 1);
  endtask

  task automatic test_overwrite();
    drive(1, 2'd0, 4'h5, 1);
    drive(0, 2'd2, 4'hE, 1);
    drive(1, 2'd0, 4'h6, 1);
    drive(1, 2'd1, 4'h7, 1);
    drive(1, 2'd2, 4'h8, 1);
    drive(1, 2'd3, 4'h9, 1);
    n_vec++; if (out_word !== 16'h9876) begin n_err++; $display("FAIL overwrite.word: got %h expected 9876", out_word); end
    n_vec++; if (out_partial !== 1'b0) begin n_err++; $display("FAIL overwrite.partial: got %b expected 0", out_partial); end
    drive(0, 2'd0, 4'h0, 1);
  endtask

  // Word k has lanes 0..2 = 1,2,3 and lane 3 = k.
  task automatic push_word(input int k, input bit r_close);
    drive(1, 2'd0, 4'h1, 0);
    drive(1, 2'd1, 4'h2, 0);
    drive(1, 2'd2, 4'h3, 0);
    drive(1, 2'd3, 4'(k), r_close);
  endtask

  task automatic test_overflow();
    logic [15:0] held;
    for (int k = 0; k < DEPTH + 1; k++) push_word(k + 1, 0);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL overflow.level: got %0d expected 4", level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow.flag: got %b expected 1", overflow); end
    held = out_word;
    drive(0, 2'd0, 4'h0, 0);
    n_vec++; if (out_word !== 16'h1321) begin n_err++; $display("FAIL overflow.stable: got %h expected 1321 (held %h)", out_word, held); end
    for (int k = 0; k < DEPTH; k++) begin
      n_vec++; if (out_word !== {4'(k + 1), 12'h321}) begin n_err++; $display("FAIL overflow.order%0d: got %h expected %h", k, out_word, {4'(k + 1), 12'h321}); end
      drive(0, 2'd0, 4'h0, 1);
    end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL overflow.drained: got %0d expected 0", level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow.sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_with_pop();
    reset_assert();
    reset_release();
    for (int k = 0; k < DEPTH; k++) push_word(k + 1, 0);
    push_word(9, 1);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_pop.level: got %0d expected 4", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop.overflow: got %b expected 0", overflow); end
    for (int k = 0; k < DEPTH; k++) begin
      n_vec++; if (out_word !== {(k == DEPTH - 1) ? 4'h9 : 4'(k + 2), 12'h321}) begin n_err++; $display("FAIL full_pop.order%0d: got %h expected %h", k, out_word, {(k == DEPTH - 1) ? 4'h9 : 4'(k + 2), 12'h321}); end
      drive(0, 2'd0, 4'h0, 1);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_pop.empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midword();
    push_word(3, 0);
    push_word(4, 0);
    drive(1, 2'd0, 4'h1, 0);
    drive(1, 2'd1, 4'h2, 0);
    #2;
    reset_assert();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset.valid: got %b expected 0", out_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_reset.level: got %0d expected 0", level); end
    reset_release();
    drive(1, 2'd2, 4'hC, 1);
    drive(1, 2'd3, 4'hD, 1);
    n_vec++; if (out_word !== 16'hDC00) begin n_err++; $display("FAIL mid_reset.word: got %h expected DC00", out_word); end
    n_vec++; if (out_partial !== 1'b1) begin n_err++; $display("FAIL mid_reset.partial: got %b expected 1", out_partial); end
    drive(0, 2'd0, 4'h0, 1);
  endtask

  task automatic test_random();
    logic [16:0] h;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 2) == 0));
      h = (mq.size() != 0) ? mq[0] : 17'h0;
      n_vec++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL random.valid@%0d: got %b expected %b", i, out_valid, (mq.size() != 0)); end
      n_vec++; if (level !== 3'(mq.size())) begin n_err++; $display("FAIL random.level@%0d: got %0d expected %0d", i, level, mq.size()); end
      n_vec++; if (out_word !== h[15:0]) begin n_err++; $display("FAIL random.word@%0d: got %h expected %h", i, out_word, h[15:0]); end
      n_vec++; if (out_partial !== h[16]) begin n_err++; $display("FAIL random.partial@%0d: got %b expected %b", i, out_partial, h[16]); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL random.overflow@%0d: got %b expected %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    sel       = 2'd0;
    data      = 4'h0;
    out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_overwrite();
    test_overflow();
    test_full_with_pop();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
